calc_key_sequencer: RTL and testbench

Front-end stage of the 4-bit fixed-point calculator, sitting directly upstream of the combinational arithmetic core. Synchronises and debounces the four active-low push buttons, converts one clean press into exactly one operation request, and snapshots the switch operands at the press. Hands the request to the arithmetic/display stage over a valid/ready handshake, so button bounce or a long hold never produces repeated or torn results.

---
 rtl/calc_key_sequencer.sv | 139 +++++++++++++
 tb/tb_calc_key_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_sequencer.sv
// Key front-end for the 4-bit calculator: sync + debounce four active-low buttons and
// turn one clean press into one valid/ready request. Optional macro: CALC_DIV0_GUARD_EN.
module calc_key_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DATA_W          = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        key_n,
  input  logic [DATA_W-1:0] sw_a,
  input  logic [DATA_W-1:0] sw_b,
  input  logic              op_ready,
  output logic              op_valid,
  output logic [1:0]        op_code,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              err_multi,
  output logic              err_div0
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_REL} state_t;

  state_t              r_state;
  logic [3:0]          r_k_s1, r_k_s2, r_deb, r_deb_prev;
  logic [3:0][CW-1:0]  r_cnt;
  logic [DATA_W-1:0]   r_a_s1, r_a_s2, r_b_s1, r_b_s2;
  logic                r_valid, r_err_multi, r_err_div0;
  logic [1:0]          r_code;
  logic [DATA_W-1:0]   r_a, r_b;

  logic [3:0]          w_low;
  logic                w_press, w_single, w_div0;
  logic [1:0]          w_idx;

  // Synchronisers for keys (idle high) and switch operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k_s1 <= 4'hF;
      r_k_s2 <= 4'hF;
      r_a_s1 <= '0;
      r_a_s2 <= '0;
      r_b_s1 <= '0;
      r_b_s2 <= '0;
    end else begin
      r_k_s1 <= key_n;
      r_k_s2 <= r_k_s1;
      r_a_s1 <= sw_a;
      r_a_s2 <= r_a_s1;
      r_b_s1 <= sw_b;
      r_b_s2 <= r_b_s1;
    end
  end

  // Debounce: level accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb      <= 4'hF;
      r_deb_prev <= 4'hF;
      r_cnt      <= '0;
    end else begin
      r_deb_prev <= r_deb;
      for (int k = 0; k < 4; k++) begin
        if (r_k_s2[k] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_MAX) begin
          r_deb[k] <= r_k_s2[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign w_low    = ~r_deb;
  assign w_press  = |(r_deb_prev & ~r_deb);
  assign w_single = (w_low != 4'h0) && ((w_low & (w_low - 4'h1)) == 4'h0);

  always_comb begin
    w_idx = 2'd0;
    for (int k = 0; k < 4; k++)
      if (w_low[k]) w_idx = 2'(k);
  end

`ifdef CALC_DIV0_GUARD_EN
  assign w_div0 = (w_idx == 2'd3) && (r_b_s2 == '0);
`else
  assign w_div0 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_valid     <= 1'b0;
      r_code      <= 2'd0;
      r_a         <= '0;
      r_b         <= '0;
      r_err_multi <= 1'b0;
      r_err_div0  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_press) begin
          if (!w_single) begin
            r_err_multi <= 1'b1;
            r_err_div0  <= 1'b0;
            r_state     <= WAIT_REL;
          end else if (w_div0) begin
            r_err_multi <= 1'b0;
            r_err_div0  <= 1'b1;
            r_state     <= WAIT_REL;
          end else begin
            r_code      <= w_idx;
            r_a         <= r_a_s2;
            r_b         <= r_b_s2;
            r_err_multi <= 1'b0;
            r_err_div0  <= 1'b0;
            r_valid     <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: if (op_ready) begin
          r_valid <= 1'b0;
          r_state <= WAIT_REL;
        end
        WAIT_REL: if (&r_deb) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign op_valid  = r_valid;
  assign op_code   = r_code;
  assign op_a      = r_a;
  assign op_b      = r_b;
  assign err_multi = r_err_multi;
  assign err_div0  = r_err_div0;
endmodule

// File: tb/tb_calc_key_sequencer.sv
// Randomised + directed bench for calc_key_sequencer against a history-based behavioural model.
module tb_calc_key_sequencer;
  localparam int D = 4;
  localparam int DW = 4;
`ifdef CALC_DIV0_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    key_n = 4'hF;
  logic [DW-1:0] sw_a = '0, sw_b = '0;
  logic          op_ready = 1'b0;
  logic          op_valid, err_multi, err_div0;
  logic [1:0]    op_code;
  logic [DW-1:0] op_a, op_b;

  int vectors = 0, errs = 0, nxfer = 0;

  calc_key_sequencer #(.DEBOUNCE_CYCLES(D), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .sw_a(sw_a), .sw_b(sw_b),
    .op_ready(op_ready), .op_valid(op_valid), .op_code(op_code), .op_a(op_a),
    .op_b(op_b), .err_multi(err_multi), .err_div0(err_div0));

  always #5 clk = ~clk;

  // Behavioural model: input histories, deb flips once the last D synced samples all disagree
  logic [3:0]    kh [0:D+1];
  logic [DW-1:0] ah [0:2], bh [0:2];
  logic [3:0]    mdeb, mdeb_prev;
  int            mode;  // 0 waiting for press, 1 request pending, 2 waiting for release
  logic          m_valid, m_emul, m_ediv;
  logic [1:0]    m_code;
  logic [DW-1:0] m_a, m_b;

  task automatic model_reset();
    for (int j = 0; j <= D + 1; j++) kh[j] = 4'hF;
    for (int j = 0; j < 3; j++) begin ah[j] = '0; bh[j] = '0; end
    mdeb = 4'hF; mdeb_prev = 4'hF; mode = 0;
    m_valid = 0; m_emul = 0; m_ediv = 0; m_code = 0; m_a = 0; m_b = 0;
  endtask

  task automatic model_step();
    logic [3:0] low;
    int idx;
    bit all;
    for (int j = D + 1; j > 0; j--) kh[j] = kh[j-1];
    for (int j = 2; j > 0; j--) begin ah[j] = ah[j-1]; bh[j] = bh[j-1]; end
    kh[0] = key_n; ah[0] = sw_a; bh[0] = sw_b;
    low = ~mdeb;
    if (mode == 0) begin
      if ((mdeb_prev & ~mdeb) != 4'h0) begin
        if ($countones(low) == 1) begin
          idx = 0;
          for (int k = 0; k < 4; k++) if (low[k]) idx = k;
          if (GUARD && idx == 3 && bh[2] == 0) begin
            m_ediv = 1; m_emul = 0; mode = 2;
          end else begin
            m_code = 2'(idx); m_a = ah[2]; m_b = bh[2];
            m_emul = 0; m_ediv = 0; m_valid = 1; mode = 1;
          end
        end else begin
          m_emul = 1; m_ediv = 0; mode = 2;
        end
      end
    end else if (mode == 1) begin
      if (op_ready) begin m_valid = 0; mode = 2; end
    end else if (mdeb == 4'hF) begin
      mode = 0;
    end
    mdeb_prev = mdeb;
    for (int k = 0; k < 4; k++) begin
      all = 1;
      for (int j = 2; j <= D + 1; j++) if (kh[j][k] == mdeb[k]) all = 0;
      if (all) mdeb[k] = ~mdeb[k];
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(posedge clk);
    if (rst_n && op_valid && op_ready) nxfer++;
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("op_valid", 32'(op_valid), 32'(m_valid));
    chk("op_code", 32'(op_code), 32'(m_code));
    chk("op_a", 32'(op_a), 32'(m_a));
    chk("op_b", 32'(op_b), 32'(m_b));
    chk("err_multi", 32'(err_multi), 32'(m_emul));
    chk("err_div0", 32'(err_div0), 32'(m_ediv));
  end

  task automatic press(input logic [3:0] k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    sw_a = a; sw_b = b; key_n = k;
  endtask

  task automatic wait_valid(input string nm, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (op_valid) begin n = i; break; end
    end
    if (n < 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic release_keys();
    @(negedge clk);
    key_n = 4'hF; op_ready = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  initial begin
    int n, x0;
    logic [3:0] t;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(op_valid), 32'd0);
    chk("reset_code", 32'(op_code), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ADD 5+3, ready already high: 7 edges from fall, one pulse only
    op_ready = 1'b1;
    press(4'b1110, 4'd5, 4'd3);
    wait_valid("add", n);
    chk("add_latency", 32'(n), 32'd7);
    chk("add_code", 32'(op_code), 32'd0);
    chk("add_a", 32'(op_a), 32'd5);
    chk("add_b", 32'(op_b), 32'd3);
    repeat (20) @(negedge clk);
    release_keys();
    chk("add_xfers", 32'(nxfer), 32'd1);

    // SUB with bounce, ready held off for 5 cycles
    op_ready = 1'b0; sw_a = 4'd3; sw_b = 4'd5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      key_n = ((i / 2) % 2 == 0) ? 4'b1101 : 4'b1111;
    end
    @(negedge clk); key_n = 4'b1101;
    wait_valid("sub", n);
    repeat (5) @(negedge clk);
    chk("sub_hold_valid", 32'(op_valid), 32'd1);
    chk("sub_code", 32'(op_code), 32'd1);
    chk("sub_a", 32'(op_a), 32'd3);
    chk("sub_b", 32'(op_b), 32'd5);
    op_ready = 1'b1;
    @(posedge clk); #1;
    chk("sub_drop", 32'(op_valid), 32'd0);
    release_keys();
    chk("sub_xfers", 32'(nxfer), 32'd2);

    // Two keys together, then clean MUL
    press(4'b1001, 4'd1, 4'd1);
    repeat (15) @(negedge clk);
    chk("multi_err", 32'(err_multi), 32'd1);
    chk("multi_xfers", 32'(nxfer), 32'd2);
    release_keys();
    press(4'b1011, 4'd4, 4'd2);
    wait_valid("mul", n);
    chk("mul_code", 32'(op_code), 32'd2);
    chk("mul_a", 32'(op_a), 32'd4);
    chk("mul_b", 32'(op_b), 32'd2);
    chk("mul_err", 32'(err_multi), 32'd0);
    release_keys();

    // DIV 9/3 and DIV 7/0
    press(4'b0111, 4'd9, 4'd3);
    wait_valid("div", n);
    chk("div_code", 32'(op_code), 32'd3);
    chk("div_a", 32'(op_a), 32'd9);
    chk("div_b", 32'(op_b), 32'd3);
    release_keys();
    x0 = nxfer;
    press(4'b0111, 4'd7, 4'd0);
`ifdef CALC_DIV0_GUARD_EN
    repeat (15) @(negedge clk);
    chk("div0_err", 32'(err_div0), 32'd1);
    chk("div0_xfers", 32'(nxfer), 32'(x0));
`else
    wait_valid("div0", n);
    chk("div0_code", 32'(op_code), 32'd3);
    chk("div0_b", 32'(op_b), 32'd0);
    chk("div0_err", 32'(err_div0), 32'd0);
`endif
    release_keys();

    // Operand change while pending
    op_ready = 1'b0;
    press(4'b1110, 4'd15, 4'd1);
    wait_valid("hold", n);
    @(negedge clk); sw_a = 4'd1;
    repeat (5) @(negedge clk);
    chk("hold_a", 32'(op_a), 32'd15);
    release_keys();

    // Reset during ISSUE with key held
    op_ready = 1'b0;
    press(4'b1110, 4'd2, 4'd6);
    wait_valid("rst", n);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 chk("rst_async_drop", 32'(op_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_valid("rst_again", n);
    chk("rst_relatency", 32'(n), 32'd7);
    chk("rst_a", 32'(op_a), 32'd2);
    release_keys();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      op_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin sw_a = DW'($urandom); sw_b = DW'($urandom_range(0, 3)); end
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 4))
          0, 1: key_n = 4'hF;
          2, 3: begin t = 4'b0001 << $urandom_range(0, 3); key_n = ~t; end
          default: key_n = 4'($urandom);
        endcase
      end
    end
    release_keys();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
